text_writer: RTL and testbench

TEXT_WRITER -- requirements
Module: text_writer

---
 rtl/text_writer.sv | 137 +++++++++++++
 tb/tb_text_writer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/text_writer.sv
// Character-cell text writer: turns a byte stream into video-memory writes,
// handling CR/LF/BS/FF and clearing the new row or the whole screen.
module text_writer #(
  parameter int          COLS       = 100,
  parameter int          ROWS       = 37,
  parameter logic [3:0]  BLANK_FORE = 4'd7,
  parameter logic [3:0]  BLANK_BACK = 4'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_byte,
  input  logic [3:0]  attr_fore,
  input  logic [3:0]  attr_back,
  input  logic        attr_blink,
  output logic        write,
  output logic [6:0]  xtextwrite,
  output logic [5:0]  ytextwrite,
  output logic [16:0] value,
  output logic [6:0]  cursor_x,
  output logic [5:0]  cursor_y
);

  localparam logic [16:0] BLANK = {1'b0, BLANK_BACK, BLANK_FORE, 8'h20};
  localparam logic [6:0]  XMAX  = 7'(COLS - 1);
  localparam logic [5:0]  YMAX  = 6'(ROWS - 1);
  localparam logic [6:0]  XEND  = 7'(COLS);
  localparam logic [6:0]  YEND  = 7'(ROWS);

  typedef enum logic [1:0] {IDLE, CLRLINE, CLRSCREEN} state_t;

  state_t     state;
  logic [6:0] clr_x;
  logic [6:0] clr_y;
  logic       accept;
  logic       printable;
  logic [5:0] y_next;

  assign in_ready  = (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign printable = (in_byte >= 8'h20) && (in_byte != 8'h7F);
  assign y_next    = (cursor_y == YMAX) ? 6'd0 : cursor_y + 6'd1;

  // Clear counters hold the next cell to blank; the terminal count value
  // (XEND / YEND) is a one-cycle tail so in_ready rises after the last write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      write      <= 1'b0;
      xtextwrite <= '0;
      ytextwrite <= '0;
      value      <= '0;
      cursor_x   <= '0;
      cursor_y   <= '0;
      clr_x      <= '0;
      clr_y      <= '0;
    end else begin
      write <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          if (printable) begin
            write      <= 1'b1;
            xtextwrite <= cursor_x;
            ytextwrite <= cursor_y;
            value      <= {attr_blink, attr_back, attr_fore, in_byte};
            if (cursor_x == XMAX) begin
              cursor_x <= '0;
              cursor_y <= y_next;
              clr_x    <= '0;
              state    <= CLRLINE;
            end else begin
              cursor_x <= cursor_x + 7'd1;
            end
          end else begin
            case (in_byte)
              8'h0D: cursor_x <= '0;
              8'h0A: begin
                // Blank column 0 right away; the clear runs from column 1.
                cursor_x   <= '0;
                cursor_y   <= y_next;
                write      <= 1'b1;
                xtextwrite <= '0;
                ytextwrite <= y_next;
                value      <= BLANK;
                clr_x      <= 7'd1;
                state      <= CLRLINE;
              end
              8'h08: if (cursor_x != '0) cursor_x <= cursor_x - 7'd1;
              8'h0C: begin
                cursor_x   <= '0;
                cursor_y   <= '0;
                write      <= 1'b1;
                xtextwrite <= '0;
                ytextwrite <= '0;
                value      <= BLANK;
                clr_x      <= 7'd1;
                clr_y      <= '0;
                state      <= CLRSCREEN;
              end
              default: ;
            endcase
          end
        end
        CLRLINE: begin
          if (clr_x == XEND) begin
            state <= IDLE;
          end else begin
            write      <= 1'b1;
            xtextwrite <= clr_x;
            ytextwrite <= cursor_y;
            value      <= BLANK;
            clr_x      <= clr_x + 7'd1;
          end
        end
        CLRSCREEN: begin
          if (clr_y == YEND) begin
            state <= IDLE;
          end else begin
            write      <= 1'b1;
            xtextwrite <= clr_x;
            ytextwrite <= clr_y[5:0];
            value      <= BLANK;
            if (clr_x == XMAX) begin
              clr_x <= '0;
              clr_y <= clr_y + 7'd1;
            end else begin
              clr_x <= clr_x + 7'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_writer.sv
// Randomized scoreboard bench for text_writer: a cell/cycle-level model
// predicts every write, the cursor and in_ready; a monitor compares.
module tb_text_writer;
  localparam int COLS = 100;
  localparam int ROWS = 37;
  localparam logic [16:0] BLANK = 17'h00720;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_byte = '0;
  logic [3:0]  attr_fore = '0;
  logic [3:0]  attr_back = '0;
  logic        attr_blink = 1'b0;
  logic        write;
  logic [6:0]  xtextwrite;
  logic [5:0]  ytextwrite;
  logic [16:0] value;
  logic [6:0]  cursor_x;
  logic [5:0]  cursor_y;

  text_writer #(.COLS(COLS), .ROWS(ROWS), .BLANK_FORE(4'd7), .BLANK_BACK(4'd0)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_byte(in_byte), .attr_fore(attr_fore), .attr_back(attr_back),
    .attr_blink(attr_blink), .write(write), .xtextwrite(xtextwrite),
    .ytextwrite(ytextwrite), .value(value), .cursor_x(cursor_x), .cursor_y(cursor_y)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int x; int y; int v; } wr_t;
  typedef struct { int cyc; int x; int y; } cur_t;

  wr_t  exp_q[$];
  cur_t cur_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   mx = 0, my = 0;
  int   cur_x = 0, cur_y = 0;
  int   acc_cyc = 0, ready_cyc = 0;
  bit   tb_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_wr(input int c, input int x, input int y, input int v);
    wr_t w;
    w.cyc = c; w.x = x; w.y = y; w.v = v;
    exp_q.push_back(w);
  endtask

  // Reference model: what a byte accepted at cycle n does to screen and cursor.
  task automatic model_accept(input logic [7:0] b, input logic [3:0] f,
                              input logic [3:0] bk, input logic bl, input int n);
    cur_t c;
    acc_cyc   = n;
    ready_cyc = n + 1;
    if (b >= 8'h20 && b != 8'h7F) begin
      push_wr(n + 1, mx, my, int'({bl, bk, f, b}));
      if (mx == COLS - 1) begin
        mx = 0;
        my = (my + 1) % ROWS;
        for (int i = 0; i < COLS; i++) push_wr(n + 2 + i, i, my, int'(BLANK));
        ready_cyc = n + 2 + COLS;
      end else begin
        mx++;
      end
    end else if (b == 8'h0A) begin
      mx = 0;
      my = (my + 1) % ROWS;
      for (int i = 0; i < COLS; i++) push_wr(n + 1 + i, i, my, int'(BLANK));
      ready_cyc = n + 1 + COLS;
    end else if (b == 8'h0C) begin
      mx = 0;
      my = 0;
      for (int i = 0; i < ROWS * COLS; i++) push_wr(n + 1 + i, i % COLS, i / COLS, int'(BLANK));
      ready_cyc = n + 1 + ROWS * COLS;
    end else if (b == 8'h0D) begin
      mx = 0;
    end else if (b == 8'h08) begin
      if (mx > 0) mx--;
    end
    c.cyc = n + 1; c.x = mx; c.y = my;
    cur_q.push_back(c);
  endtask

  task automatic model_reset();
    exp_q.delete();
    cur_q.delete();
    mx = 0; my = 0; cur_x = 0; cur_y = 0;
    acc_cyc = 0; ready_cyc = 0;
  endtask

  // Called at posedge+1; holds the byte until accepted, returns at posedge+1.
  task automatic send(input logic [7:0] b, input logic [3:0] f,
                      input logic [3:0] bk, input logic bl);
    in_valid = 1'b1; in_byte = b; attr_fore = f; attr_back = bk; attr_blink = bl;
    for (int t = 0; t < 5000; t++) begin
      if (in_ready) begin
        model_accept(b, f, bk, bl, cyc);
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    check("send_timeout", 0, 1);
  endtask

  task automatic send_rand_print();
    logic [7:0] b;
    b = 8'($urandom_range(32, 255));
    if (b == 8'h7F) b = 8'h41;
    send(b, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (reset_n && !tb_done) begin
      while (cur_q.size() > 0 && cur_q[0].cyc <= cyc) begin
        cur_x = cur_q[0].x; cur_y = cur_q[0].y;
        void'(cur_q.pop_front());
      end
      check("cursor_yx", int'(cursor_y) * 256 + int'(cursor_x), cur_y * 256 + cur_x);
      check("in_ready", int'(in_ready), (cyc > acc_cyc && cyc < ready_cyc) ? 0 : 1);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        check("missed_write_cycle", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (write) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("write_cycle", cyc, e.cyc);
          check("write_x", int'(xtextwrite), e.x);
          check("write_y", int'(ytextwrite), e.y);
          check("write_value", int'(value), e.v);
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_write", int'(write), 0);
    check("rst_x", int'(xtextwrite), 0);
    check("rst_y", int'(ytextwrite), 0);
    check("rst_value", int'(value), 0);
    check("rst_cursor", int'(cursor_y) * 256 + int'(cursor_x), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(2);

    // 'A' fore=2 back=1 -> value 0x01241 at (0,0)
    send(8'h41, 4'd2, 4'd1, 1'b0);
    idle(2);
    send(8'h0D, 4'd0, 4'd0, 1'b0);
    for (int i = 0; i < 5; i++) send(8'h0A, 4'd0, 4'd0, 1'b0);
    // back-to-back printables up to column 99, then wrap
    for (int i = 0; i < COLS - 1; i++) send_rand_print();
    send(8'h42, 4'd3, 4'd4, 1'b1);
    for (int i = 0; i < 30; i++) send(8'h0A, 4'd0, 4'd0, 1'b0);
    for (int i = 0; i < 10; i++) send_rand_print();
    // LF from the last row wraps to row 0
    send(8'h0A, 4'd0, 4'd0, 1'b0);
    idle(3);
    // FF with 'Z' held valid throughout the clear
    send(8'h0C, 4'd0, 4'd0, 1'b0);
    send(8'h5A, 4'd5, 4'd6, 1'b0);
    send(8'h0D, 4'd0, 4'd0, 1'b0);
    for (int i = 0; i < 3; i++) send(8'h0A, 4'd0, 4'd0, 1'b0);
    send(8'h08, 4'd0, 4'd0, 1'b0);
    send(8'h0D, 4'd0, 4'd0, 1'b0);
    send(8'h01, 4'd0, 4'd0, 1'b0);
    idle(3);

    for (int i = 0; i < 150; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 70)      send_rand_print();
      else if (r < 78) send(8'h0A, 4'd0, 4'd0, 1'b0);
      else if (r < 84) send(8'h0D, 4'd0, 4'd0, 1'b0);
      else if (r < 90) send(8'h08, 4'd0, 4'd0, 1'b0);
      else if (r < 91) send(8'h0C, 4'd0, 4'd0, 1'b0);
      else if (r < 95) send(8'h7F, 4'd0, 4'd0, 1'b0);
      else             send(8'($urandom_range(0, 31)), 4'd0, 4'd0, 1'b0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(2);

    // Reset in the middle of a screen clear
    send(8'h0C, 4'd0, 4'd0, 1'b0);
    idle(1000);
    reset_n = 1'b0;
    model_reset();
    #1;
    check("midrst_write", int'(write), 0);
    check("midrst_cursor", int'(cursor_y) * 256 + int'(cursor_x), 0);
    check("midrst_value", int'(value), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(20);
    send(8'h43, 4'd1, 4'd2, 1'b1);
    idle(2);

    for (int t = 0; t < 5000 && exp_q.size() > 0; t++) @(posedge clk);
    @(negedge clk);
    check("drain", exp_q.size(), 0);
    tb_done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
